// File: rtl/sync_pkg.sv
// Shared encodings and width helper for the sync_debounce qualifier.
// No logic; no latency; no backpressure.
package sync_pkg;

    localparam logic ST_IDLE    = 1'b0;
    localparam logic ST_QUALIFY = 1'b1;

    function automatic int clog2(input int value);
        int res;
        res = 0;
        while ((1 << res) < value) begin
            res = res + 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/sync_sat_counter.sv
// Saturating up-counter with a clear and an increment enable. Clear together with increment loads 1.
// Latency: 1 cycle (registered). Backpressure: none; the count holds at all-ones.
module sync_sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = inc ? WIDTH'(1) : '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/sync_debounce.sv
// Debounces a synchronized level and emits rise/fall pulses, a sticky change flag and an event count.
// Latency: STABLE_CYCLES cycles from the first differing sample. Backpressure: none; all outputs registered.
module sync_debounce
    import sync_pkg::*;
#(
    parameter int   STABLE_CYCLES   = 16,
    parameter logic INIT_LEVEL      = 1'b0,
    parameter int   EVENT_CNT_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       data_sync,
    output logic                       level_out,
    output logic                       rise_pulse,
    output logic                       fall_pulse,
    output logic                       change_sticky,
    input  logic                       sticky_clr,
    output logic [EVENT_CNT_WIDTH-1:0] event_count,
    input  logic                       count_clr
);

    localparam int QW = clog2(STABLE_CYCLES) + 1;
    localparam logic [QW-1:0] QCNT_LAST = QW'(STABLE_CYCLES - 1);

    logic          state_q,  state_d;
    logic [QW-1:0] qcnt_q,   qcnt_d;
    logic          level_q,  level_d;
    logic          rise_q,   rise_d;
    logic          fall_q,   fall_d;
    logic          sticky_q, sticky_d;
    logic          accept;
    logic          differs;

    always_comb begin
        differs = (data_sync != level_q);
        state_d = state_q;
        qcnt_d  = qcnt_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (differs) begin
                    if (STABLE_CYCLES == 1) begin
                        accept = 1'b1;
                    end else begin
                        state_d = ST_QUALIFY;
                        qcnt_d  = QW'(1);
                    end
                end
            end
            default: begin
                if (!differs) begin
                    state_d = ST_IDLE;
                    qcnt_d  = '0;
                end else if (qcnt_q == QCNT_LAST) begin
                    accept  = 1'b1;
                    state_d = ST_IDLE;
                    qcnt_d  = '0;
                end else begin
                    qcnt_d  = qcnt_q + QW'(1);
                end
            end
        endcase

        // The pulse direction is taken from the level being left.
        level_d  = accept ? ~level_q : level_q;
        rise_d   = accept & ~level_q;
        fall_d   = accept &  level_q;
        sticky_d = accept | (sticky_q & ~sticky_clr);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            qcnt_q   <= '0;
            level_q  <= INIT_LEVEL;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            qcnt_q   <= qcnt_d;
            level_q  <= level_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            sticky_q <= sticky_d;
        end
    end

    sync_sat_counter #(
        .WIDTH (EVENT_CNT_WIDTH)
    ) u_event_cnt (
        .clk    (clk),
        .resetn (resetn),
        .clr    (count_clr),
        .inc    (accept),
        .cnt    (event_count)
    );

    assign level_out     = level_q;
    assign rise_pulse    = rise_q;
    assign fall_pulse    = fall_q;
    assign change_sticky = sticky_q;

endmodule

// File: tb/tb_sync_debounce.sv
// Table-driven bench for sync_debounce: three parameterisations, expected outputs queued per driven cycle.
module tb_sync_debounce;

    typedef struct {
        bit       rst_n;
        bit       din;
        bit       sclr;
        bit       cclr;
        bit       lvl;
        bit       rise;
        bit       fall;
        bit       stk;
        bit [7:0] cnt;
    } vec_t;

    typedef struct {
        int       idx;
        bit [11:0] val;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // A: STABLE_CYCLES=16, INIT 0, 8-bit count
    logic       rst_a = 1'b0, din_a = 1'b0, sclr_a = 1'b0, cclr_a = 1'b0;
    logic       lvl_a, rise_a, fall_a, stk_a;
    logic [7:0] cnt_a;
    // B: STABLE_CYCLES=1, INIT 0, 2-bit count
    logic       rst_b = 1'b0, din_b = 1'b0, sclr_b = 1'b0, cclr_b = 1'b0;
    logic       lvl_b, rise_b, fall_b, stk_b;
    logic [1:0] cnt_b;
    // C: STABLE_CYCLES=16, INIT 1, 8-bit count
    logic       rst_c = 1'b0, din_c = 1'b0, sclr_c = 1'b0, cclr_c = 1'b0;
    logic       lvl_c, rise_c, fall_c, stk_c;
    logic [7:0] cnt_c;

    sync_debounce #(.STABLE_CYCLES(16), .INIT_LEVEL(1'b0), .EVENT_CNT_WIDTH(8)) dut_a (
        .clk(clk), .resetn(rst_a), .data_sync(din_a), .level_out(lvl_a),
        .rise_pulse(rise_a), .fall_pulse(fall_a), .change_sticky(stk_a),
        .sticky_clr(sclr_a), .event_count(cnt_a), .count_clr(cclr_a));

    sync_debounce #(.STABLE_CYCLES(1), .INIT_LEVEL(1'b0), .EVENT_CNT_WIDTH(2)) dut_b (
        .clk(clk), .resetn(rst_b), .data_sync(din_b), .level_out(lvl_b),
        .rise_pulse(rise_b), .fall_pulse(fall_b), .change_sticky(stk_b),
        .sticky_clr(sclr_b), .event_count(cnt_b), .count_clr(cclr_b));

    sync_debounce #(.STABLE_CYCLES(16), .INIT_LEVEL(1'b1), .EVENT_CNT_WIDTH(8)) dut_c (
        .clk(clk), .resetn(rst_c), .data_sync(din_c), .level_out(lvl_c),
        .rise_pulse(rise_c), .fall_pulse(fall_c), .change_sticky(stk_c),
        .sticky_clr(sclr_c), .event_count(cnt_c), .count_clr(cclr_c));

    vec_t vecs[$];
    exp_t exp_q[$];
    int   n_pass = 0;
    int   n_total = 0;
    string tag;

    function automatic void add(bit r, bit d, bit sc, bit cc,
                                bit l, bit ri, bit fa, bit st, bit [7:0] c);
        vec_t v;
        v.rst_n = r; v.din = d; v.sclr = sc; v.cclr = cc;
        v.lvl = l; v.rise = ri; v.fall = fa; v.stk = st; v.cnt = c;
        vecs.push_back(v);
    endfunction

    function automatic void addn(int n, bit r, bit d, bit sc, bit cc,
                                 bit l, bit ri, bit fa, bit st, bit [7:0] c);
        for (int i = 0; i < n; i++) add(r, d, sc, cc, l, ri, fa, st, c);
    endfunction

    function automatic bit [11:0] sample(input int sel);
        case (sel)
            0:       return {lvl_a, rise_a, fall_a, stk_a, cnt_a};
            1:       return {lvl_b, rise_b, fall_b, stk_b, 6'd0, cnt_b};
            default: return {lvl_c, rise_c, fall_c, stk_c, cnt_c};
        endcase
    endfunction

    task automatic check_one(input int sel);
        exp_t e;
        bit [11:0] act;
        e = exp_q.pop_front();
        act = sample(sel);
        n_total++;
        if (act === e.val) begin
            n_pass++;
        end else begin
            $display("FAIL %s vec%0d: got lvl/rise/fall/stk=%b cnt=%0d, want lvl/rise/fall/stk=%b cnt=%0d",
                     tag, e.idx, act[11:8], act[7:0], e.val[11:8], e.val[7:0]);
        end
    endtask

    task automatic run_vectors(input int sel);
        exp_t e;
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            if (exp_q.size() > 0) check_one(sel);
            case (sel)
                0: begin rst_a = vecs[i].rst_n; din_a = vecs[i].din; sclr_a = vecs[i].sclr; cclr_a = vecs[i].cclr; end
                1: begin rst_b = vecs[i].rst_n; din_b = vecs[i].din; sclr_b = vecs[i].sclr; cclr_b = vecs[i].cclr; end
                default: begin rst_c = vecs[i].rst_n; din_c = vecs[i].din; sclr_c = vecs[i].sclr; cclr_c = vecs[i].cclr; end
            endcase
            e.idx = i;
            e.val = {vecs[i].lvl, vecs[i].rise, vecs[i].fall, vecs[i].stk, vecs[i].cnt};
            exp_q.push_back(e);
        end
        @(negedge clk);
        if (exp_q.size() > 0) check_one(sel);
        vecs.delete();
    endtask

    initial begin
        // A: clean rise, glitch rejection both ways, sticky race, count clear
        addn(2, 0,0,0,0, 0,0,0,0,0);
        addn(15,1,1,0,0, 0,0,0,0,0);
        add (   1,1,0,0, 1,1,0,1,1);
        add (   1,1,0,0, 1,0,0,1,1);
        addn(15,1,0,0,0, 1,0,0,1,1);
        add (   1,1,0,0, 1,0,0,1,1);
        addn(15,1,0,0,0, 1,0,0,1,1);
        add (   1,0,1,0, 0,0,1,1,2);
        add (   1,0,1,0, 0,0,0,0,2);
        add (   1,0,0,0, 0,0,0,0,2);
        addn(15,1,1,0,0, 0,0,0,0,2);
        add (   1,0,0,0, 0,0,0,0,2);
        addn(15,1,1,0,0, 0,0,0,0,2);
        add (   1,1,0,0, 1,1,0,1,3);
        add (   1,1,0,1, 1,0,0,1,0);
        add (   1,1,0,0, 1,0,0,1,0);
        tag = "s16";
        run_vectors(0);

        // B: immediate accept, 2-bit saturation, clear racing an accept
        addn(2, 0,0,0,0, 0,0,0,0,0);
        add (   1,1,0,0, 1,1,0,1,1);
        add (   1,0,0,0, 0,0,1,1,2);
        add (   1,1,0,0, 1,1,0,1,3);
        add (   1,0,0,0, 0,0,1,1,3);
        add (   1,1,0,0, 1,1,0,1,3);
        add (   1,0,0,1, 0,0,1,1,1);
        add (   1,0,0,1, 0,0,0,1,0);
        add (   1,0,1,0, 0,0,0,0,0);
        tag = "s1_sat";
        run_vectors(1);

        // C: reset with toggling input, quiet release, reset in mid-qualification
        for (int i = 0; i < 6; i++) add(0, i[0], 0,0, 1,0,0,0,0);
        addn(20,1,1,0,0, 1,0,0,0,0);
        addn(10,1,0,0,0, 1,0,0,0,0);
        addn(2, 0,0,0,0, 1,0,0,0,0);
        addn(15,1,0,0,0, 1,0,0,0,0);
        add (   1,0,0,0, 0,0,1,1,1);
        add (   1,0,0,0, 0,0,0,1,1);
        tag = "init1_rst";
        run_vectors(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
